// File: rtl/rca_multiword_seq.sv
// rca_multiword_seq: wide adder that reuses one 16-bit ripple-carry slice, LSB slice first.
module rca_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_start,
  output logic [15:0] sum,
  output logic        carry_out
);
  logic [16:0] c;
  always_comb begin
    c = '0;
    sum = '0;
    c[0] = carry_start;
    for (int i = 0; i < 16; i++) begin
      sum[i] = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    carry_out = c[16];
  end
endmodule

module rca_multiword_seq #(
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [16*WORDS-1:0] sum,
  output logic              cout,
  output logic              overflow
);
  localparam int W = 16 * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] a_r, b_r;
  logic [IW-1:0] idx;
  logic carry, accept, last, c_o;
  logic [15:0] s;
  rca_16bit u_rca (
    .a(a_r[{idx, 4'b0} +: 16]),
    .b(b_r[{idx, 4'b0} +: 16]),
    .carry_start(carry),
    .sum(s),
    .carry_out(c_o)
  );
  always_comb begin
    accept = state == IDLE && in_valid;
    last = idx == LAST;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    state_n = accept ? RUN :
              (state == RUN && last) ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
    overflow = out_valid && (a_r[W-1] == b_r[W-1]) && (sum[W-1] != a_r[W-1]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      carry <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_r <= a;
        b_r <= b;
        carry <= cin;
        idx <= '0;
      end
      if (state == RUN) begin
        sum[{idx, 4'b0} +: 16] <= s;
        carry <= c_o;
        idx <= last ? '0 : idx + 1'b1;
        if (last) cout <= c_o;
      end
    end
  end
endmodule

// File: tb/tb_rca_multiword_seq.sv
// tb_rca_multiword_seq: directed and random checks of the sequential wide adder against a+b+cin.
module tb_rca_multiword_seq;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, cin = 1'b0, out_ready = 1'b0;
  logic [63:0] a = '0, b = '0, sum;
  logic in_ready, out_valid, cout, overflow;
  int vectors = 0, miscompares = 0;
  logic [65:0] q[$];

  rca_multiword_seq #(.WORDS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y, input logic ci);
    logic [64:0] r;
    r = {1'b0, x} + {1'b0, y} + {64'b0, ci};
    return {r[64], (x[63] == y[63]) && (r[63] != x[63]), r[63:0]};
  endfunction

  task automatic run_op(input logic [63:0] x, input logic [63:0] y, input logic ci, input int hold);
    int lat;
    logic [65:0] e;
    logic [63:0] held;
    @(negedge clk);
    chk("ready_before", 64'(in_ready), 64'd1);
    a = x; b = y; cin = ci; in_valid = 1'b1;
    q.push_back(model(x, y, ci));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = ~x; b = ~y; cin = ~ci;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'd4);
    if (q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = q.pop_front();
      chk("sum", sum, e[63:0]);
      chk("cout", 64'(cout), 64'(e[65]));
      chk("overflow", 64'(overflow), 64'(e[64]));
    end
    held = sum;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      cin = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_ready", 64'(in_ready), 64'd0);
      chk("hold_sum", sum, held);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("ready_after", 64'(in_ready), 64'd1);
    chk("valid_after", 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", sum, 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(64'd1, 64'd1, 1'b0, 0);
    run_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 0);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 10);
    @(negedge clk);
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; cin = 1'b0; in_valid = 1'b1;
    q.push_back(model(a, b, cin));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum", sum, 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale_valid", 64'(out_valid), 64'd0);
    end
    run_op(64'd5, 64'd7, 1'b0, 0);
    for (int i = 0; i < 20; i++)
      run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), i % 3);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
